// File: rtl/timer_ctrl_pkg.sv
// timer_pkg: shared definitions for the mm:ss countdown timer.
//   - timer_state_e : controller state encoding (IDLE, RUN, PAUSE, DONE)
//   - BCD constants : largest digit, largest seconds-tens digit, field widths
//   - bcd_clamp     : saturates one BCD digit to a given limit
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } timer_state_e;

    localparam int unsigned BCD_MAX_DIGIT    = 9;
    localparam int unsigned BCD_MAX_SEC_TENS = 5;
    localparam int unsigned BCD_DIGIT_W      = 4;
    localparam int unsigned BCD_PAIR_W       = 8;
    localparam int unsigned DISP_W           = 12;

    function automatic logic [BCD_DIGIT_W-1:0] bcd_clamp(
        input logic [BCD_DIGIT_W-1:0] digit,
        input logic [BCD_DIGIT_W-1:0] limit
    );
        return (digit > limit) ? limit : digit;
    endfunction

endpackage

// File: rtl/timer_ctrl_if.sv
// timer_ctrl_if: control and display bus of the countdown timer.
//   Controls (master -> slave): start, stop, clear, load, load_mins, load_secs
//   Status   (slave -> master): mins, secs, running, done, expired, blank
// The timer_ctrl module connects through the slave modport.
interface timer_ctrl_if;
    import timer_pkg::*;

    logic                  start;
    logic                  stop;
    logic                  clear;
    logic                  load;
    logic [BCD_PAIR_W-1:0] load_mins;
    logic [BCD_PAIR_W-1:0] load_secs;
    logic [DISP_W-1:0]     mins;
    logic [DISP_W-1:0]     secs;
    logic                  running;
    logic                  done;
    logic                  expired;
    logic                  blank;

    modport master (
        output start, stop, clear, load, load_mins, load_secs,
        input  mins, secs, running, done, expired, blank
    );

    modport slave (
        input  start, stop, clear, load, load_mins, load_secs,
        output mins, secs, running, done, expired, blank
    );

endinterface

// File: rtl/timer_ctrl_bcd_mmss_dec.sv
// bcd_mmss_dec: combinational one-second decrement of a BCD mm:ss value.
//   value_i  [15:0] : {min tens, min units, sec tens, sec units}
//   value_o  [15:0] : value_i minus one second, saturating at 00:00
//   is_one_o        : value_i is exactly 00:01
module bcd_mmss_dec
    import timer_pkg::*;
(
    input  logic [15:0] value_i,
    output logic [15:0] value_o,
    output logic        is_one_o
);

    localparam logic [BCD_DIGIT_W-1:0] DIG_MAX  = BCD_DIGIT_W'(BCD_MAX_DIGIT);
    localparam logic [BCD_DIGIT_W-1:0] TENS_MAX = BCD_DIGIT_W'(BCD_MAX_SEC_TENS);

    logic [BCD_DIGIT_W-1:0] m1, m0, s1, s0;

    always_comb begin
        m1 = value_i[15:12];
        m0 = value_i[11:8];
        s1 = value_i[7:4];
        s0 = value_i[3:0];
        // Ripple borrow from seconds units upward; a nonzero value
        // guarantees some higher digit can absorb the borrow.
        if (value_i != '0) begin
            if (s0 != '0) begin
                s0 = s0 - 1'b1;
            end else begin
                s0 = DIG_MAX;
                if (s1 != '0) begin
                    s1 = s1 - 1'b1;
                end else begin
                    s1 = TENS_MAX;
                    if (m0 != '0) begin
                        m0 = m0 - 1'b1;
                    end else begin
                        m0 = DIG_MAX;
                        m1 = m1 - 1'b1;
                    end
                end
            end
        end
        value_o  = {m1, m0, s1, s0};
        is_one_o = (value_i == 16'h0001);
    end

endmodule

// File: rtl/timer_ctrl.sv
// timer_ctrl: mm:ss countdown timer controller with start/stop/clear FSM.
//   clk      : system clock, rising edge
//   rst_n    : synchronous active-low reset
//   bus      : timer_ctrl_if.slave (controls in, BCD display and status out)
//   TICK_DIV : clock cycles per one-second tick (>= 2, even)
// Optional feature macro TIMER_BLINK_EN: blink the display (blank) in DONE,
// with the prescaler free-running there; otherwise blank is tied low.
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int unsigned TICK_DIV = 100_000_000
)
(
    input  logic         clk,
    input  logic         rst_n,
    timer_ctrl_if.slave  bus
);

    localparam int unsigned     PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0]   TICK_LAST = PW'(TICK_DIV - 1);
`ifdef TIMER_BLINK_EN
    localparam logic [PW-1:0]   HALF_LAST = PW'(TICK_DIV / 2 - 1);
`endif
    localparam logic [BCD_DIGIT_W-1:0] DIG_MAX  = BCD_DIGIT_W'(BCD_MAX_DIGIT);
    localparam logic [BCD_DIGIT_W-1:0] TENS_MAX = BCD_DIGIT_W'(BCD_MAX_SEC_TENS);

    timer_state_e  state_q;
    logic [15:0]   value_q;
    logic [PW-1:0] presc_q;
    logic          running_q;
    logic          done_q;
    logic          expired_q;
`ifdef TIMER_BLINK_EN
    logic          blank_q;
`endif

    logic [15:0]   load_value_d;
    logic [15:0]   dec_value_d;
    logic          dec_is_one_d;

    always_comb begin
        load_value_d = {bcd_clamp(bus.load_mins[7:4], DIG_MAX),
                        bcd_clamp(bus.load_mins[3:0], DIG_MAX),
                        bcd_clamp(bus.load_secs[7:4], TENS_MAX),
                        bcd_clamp(bus.load_secs[3:0], DIG_MAX)};
    end

    bcd_mmss_dec u_dec (
        .value_i  (value_q),
        .value_o  (dec_value_d),
        .is_one_o (dec_is_one_d)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            value_q   <= '0;
            presc_q   <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            expired_q <= 1'b0;
`ifdef TIMER_BLINK_EN
            blank_q   <= 1'b0;
`endif
        end else begin
            expired_q <= 1'b0;
            if (bus.clear || (bus.load && state_q != RUN)) begin
                value_q   <= bus.clear ? '0 : load_value_d;
                state_q   <= IDLE;
                presc_q   <= '0;
                running_q <= 1'b0;
                done_q    <= 1'b0;
`ifdef TIMER_BLINK_EN
                blank_q   <= 1'b0;
`endif
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.start && !bus.stop && value_q != '0) begin
                            state_q   <= RUN;
                            presc_q   <= '0;
                            running_q <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (bus.stop) begin
                            // Prescaler is held so a resume finishes the
                            // interrupted second rather than restarting it.
                            state_q   <= PAUSE;
                            running_q <= 1'b0;
                        end else if (presc_q == TICK_LAST) begin
                            presc_q <= '0;
                            value_q <= dec_value_d;
                            if (dec_is_one_d) begin
                                state_q   <= DONE;
                                running_q <= 1'b0;
                                done_q    <= 1'b1;
                                expired_q <= 1'b1;
`ifdef TIMER_BLINK_EN
                                blank_q   <= 1'b1;
`endif
                            end
                        end else begin
                            presc_q <= presc_q + 1'b1;
                        end
                    end
                    PAUSE: begin
                        if (bus.start && !bus.stop) begin
                            state_q   <= RUN;
                            running_q <= 1'b1;
                        end
                    end
                    DONE: begin
                        if (bus.start && !bus.stop) begin
                            state_q <= IDLE;
                            done_q  <= 1'b0;
                            presc_q <= '0;
`ifdef TIMER_BLINK_EN
                            blank_q <= 1'b0;
`endif
                        end
`ifdef TIMER_BLINK_EN
                        else begin
                            // Toggle at each half-period boundary of the
                            // free-running prescaler.
                            if (presc_q == HALF_LAST || presc_q == TICK_LAST) begin
                                blank_q <= ~blank_q;
                            end
                            presc_q <= (presc_q == TICK_LAST) ? '0 : presc_q + 1'b1;
                        end
`endif
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.mins    = {4'h0, value_q[15:8]};
    assign bus.secs    = {4'h0, value_q[7:0]};
    assign bus.running = running_q;
    assign bus.done    = done_q;
    assign bus.expired = expired_q;
`ifdef TIMER_BLINK_EN
    assign bus.blank   = blank_q;
`else
    assign bus.blank   = 1'b0;
`endif

endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: self-checking bench for timer_ctrl with TICK_DIV = 4.
// The reference model tracks the remaining time as a plain count of seconds
// and the position inside the current second as an elapsed-cycle count.
module tb_timer_ctrl;

    localparam int TD = 4;

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;
    localparam int S_DONE  = 3;

    logic clk;
    logic rst_n;

    timer_ctrl_if bus_if ();

    timer_ctrl #(.TICK_DIV(TD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int m_total;      // remaining time in seconds
    int m_state;
    int m_elapsed;    // cycles already counted in the current second
    int m_done_cyc;   // cycles spent in DONE since entry
    bit m_expired;

    function automatic int load_seconds(input logic [7:0] lm, input logic [7:0] ls);
        int mt, mu, st, su;
        mt = int'(lm[7:4]); if (mt > 9) mt = 9;
        mu = int'(lm[3:0]); if (mu > 9) mu = 9;
        st = int'(ls[7:4]); if (st > 5) st = 5;
        su = int'(ls[3:0]); if (su > 9) su = 9;
        return (mt * 10 + mu) * 60 + st * 10 + su;
    endfunction

    function automatic logic [11:0] to_bcd(input int v);
        return {4'h0, 4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic model_step(input bit r_n, input bit c, input bit l, input bit sp,
                              input bit st, input logic [7:0] lm, input logic [7:0] ls);
        m_expired = 1'b0;
        if (!r_n || c) begin
            m_total = 0; m_state = S_IDLE; m_elapsed = 0;
        end else if (l && m_state != S_RUN) begin
            m_total = load_seconds(lm, ls); m_state = S_IDLE; m_elapsed = 0;
        end else begin
            case (m_state)
                S_IDLE:
                    if (st && !sp && m_total > 0) begin
                        m_state = S_RUN; m_elapsed = 0;
                    end
                S_RUN:
                    if (sp) begin
                        m_state = S_PAUSE;
                    end else if (m_elapsed + 1 == TD) begin
                        m_elapsed = 0;
                        m_total   = m_total - 1;
                        if (m_total == 0) begin
                            m_state = S_DONE; m_expired = 1'b1; m_done_cyc = 0;
                        end
                    end else begin
                        m_elapsed = m_elapsed + 1;
                    end
                S_PAUSE:
                    if (st && !sp) m_state = S_RUN;
                default:
                    if (st && !sp) m_state = S_IDLE;
                    else m_done_cyc = m_done_cyc + 1;
            endcase
        end
    endtask

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        logic exp_blank;
`ifdef TIMER_BLINK_EN
        exp_blank = (m_state == S_DONE) && (((m_done_cyc / (TD / 2)) % 2) == 0);
`else
        exp_blank = 1'b0;
`endif
        chk("mins",    bus_if.mins,          to_bcd(m_total / 60));
        chk("secs",    bus_if.secs,          to_bcd(m_total % 60));
        chk("running", 12'(bus_if.running),  12'(m_state == S_RUN));
        chk("done",    12'(bus_if.done),     12'(m_state == S_DONE));
        chk("expired", 12'(bus_if.expired),  12'(m_expired));
        chk("blank",   12'(bus_if.blank),    12'(exp_blank));
    endtask

    task automatic cyc(input bit r_n, input bit c, input bit l, input bit sp,
                       input bit st, input logic [7:0] lm, input logic [7:0] ls);
        rst_n            = r_n;
        bus_if.clear     = c;
        bus_if.load      = l;
        bus_if.stop      = sp;
        bus_if.start     = st;
        bus_if.load_mins = lm;
        bus_if.load_secs = ls;
        @(posedge clk);
        model_step(r_n, c, l, sp, st, lm, ls);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 8'h00, 8'h00);
    endtask

    task automatic do_load(input logic [7:0] lm, input logic [7:0] ls);
        cyc(1, 0, 1, 0, 0, lm, ls);
    endtask

    task automatic do_start();
        cyc(1, 0, 0, 0, 1, 8'h00, 8'h00);
    endtask

    task automatic do_stop();
        cyc(1, 0, 0, 1, 0, 8'h00, 8'h00);
    endtask

    initial begin
        m_total = 0; m_state = S_IDLE; m_elapsed = 0; m_done_cyc = 0; m_expired = 1'b0;

        // Reset state
        cyc(0, 0, 0, 0, 0, 8'h00, 8'h00);
        cyc(0, 1, 1, 1, 1, 8'h12, 8'h34);

        // 00:03 countdown to expiry, then acknowledge
        do_load(8'h00, 8'h03);
        do_start();
        idle(16);
        idle(6);
        do_start();

        // Borrow from minutes: 01:00 -> 00:59 -> ... -> DONE
        do_load(8'h01, 8'h00);
        do_start();
        idle(TD * 60 + 3);
        do_start();

        // Clamping of out-of-range BCD digits
        do_load(8'hAB, 8'h7C);
        idle(1);
        do_load(8'h3F, 8'hF9);

        // Start at 00:00 is ignored
        cyc(1, 1, 0, 0, 0, 8'h00, 8'h00);
        do_start();
        idle(2);

        // Pause with prescaler at 2, resume, next decrement after 2 cycles
        do_load(8'h00, 8'h10);
        do_start();
        idle(2);
        do_stop();
        idle(10);
        do_start();
        idle(6);

        // stop+start together in RUN, then in PAUSE
        cyc(1, 0, 0, 1, 1, 8'h00, 8'h00);
        cyc(1, 0, 0, 1, 1, 8'h00, 8'h00);
        do_start();
        // load in RUN is ignored
        do_load(8'h55, 8'h55);
        idle(3);
        // clear beats load
        cyc(1, 1, 1, 0, 0, 8'h22, 8'h22);

        // Reset mid-count
        do_load(8'h00, 8'h30);
        do_start();
        idle(5);
        cyc(0, 0, 1, 0, 1, 8'h11, 8'h11);
        idle(2);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            bit r, c, l, sp, st;
            logic [7:0] lm, ls;
            r  = ($urandom_range(999) != 0);
            c  = ($urandom_range(199) == 0);
            l  = ($urandom_range(59) == 0);
            sp = ($urandom_range(29) == 0);
            st = ($urandom_range(7) == 0);
            lm = ($urandom_range(5) == 0) ? 8'($urandom) : 8'h00;
            ls = ($urandom_range(1) == 0) ? 8'($urandom_range(6)) : 8'($urandom);
            cyc(r, c, l, sp, st, lm, ls);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
